// File: rtl/sfm_minmax_row_ctrl.sv
// sfm_minmax_row_ctrl: row sequencer for a FP min/max reduction datapath, tracks in-flight beats and folds per-beat results.
package sfm_pkg;
    typedef enum logic {MIN = 1'b0, MAX = 1'b1} min_max_mode_t;
endpackage

module sfm_minmax_row_ctrl #(
    parameter int WIDTH        = 16,
    parameter int LEN_WIDTH    = 16,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  sfm_pkg::min_max_mode_t mode_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  red_valid_o,
    input  logic                  red_ready_i,
    output sfm_pkg::min_max_mode_t red_mode_o,
    input  logic                  red_res_valid_i,
    output logic                  red_res_ready_o,
    input  logic [WIDTH-1:0]      red_res_i,
    input  logic                  red_res_strb_i,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [WIDTH-1:0]      result_o,
    output logic                  result_strb_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                 state, state_n;
    logic [LEN_WIDTH-1:0]   len_q, issued, returned, issued_n, returned_n;
    logic [IW-1:0]          inflight;
    sfm_pkg::min_max_mode_t mode_q;
    logic [WIDTH-1:0]       acc;
    logic                   acc_vld, issue_en, iss, ret, take;

    // Sign-magnitude FP mapped onto an unsigned total order.
    function automatic logic [WIDTH-1:0] key(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? ~x : (x | {1'b1, {(WIDTH-1){1'b0}}});
    endfunction

    assign issue_en        = (state == RUN) && (issued < len_q) && (inflight < IW'(MAX_INFLIGHT));
    assign red_valid_o     = in_valid_i & issue_en;
    assign in_ready_o      = red_ready_i & issue_en;
    assign red_res_ready_o = (state == RUN) || (state == DRAIN);
    assign red_mode_o      = mode_q;
    assign iss             = red_valid_o & red_ready_i;
    assign ret             = red_res_valid_i & red_res_ready_o;
    assign issued_n        = issued + LEN_WIDTH'(iss);
    assign returned_n      = returned + LEN_WIDTH'(ret);
    assign take            = ret & red_res_strb_i & (!acc_vld ||
                             (mode_q == sfm_pkg::MAX ? key(red_res_i) > key(acc) : key(red_res_i) < key(acc)));
    assign result_valid_o  = state == OUT;
    assign result_o        = acc;
    assign result_strb_o   = (state == OUT) & acc_vld;
    assign busy_o          = state != IDLE;
    assign done_o          = (state == OUT) & result_ready_i & ~clear_i;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else       state <= state_n;

    always_comb begin
        state_n = state;
        if (clear_i) state_n = IDLE;
        else
            unique case (state)
                IDLE:    state_n = start_i ? (len_i == '0 ? OUT : RUN) : IDLE;
                RUN:     state_n = returned_n == len_q ? OUT : (issued_n == len_q ? DRAIN : RUN);
                DRAIN:   state_n = returned_n == len_q ? OUT : DRAIN;
                default: state_n = result_ready_i ? IDLE : OUT;
            endcase
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            len_q    <= '0;
            mode_q   <= sfm_pkg::MIN;
            issued   <= '0;
            returned <= '0;
            inflight <= '0;
            acc      <= '0;
            acc_vld  <= 1'b0;
        end else if (clear_i) begin
            issued   <= '0;
            returned <= '0;
            inflight <= '0;
            acc_vld  <= 1'b0;
        end else if (state == IDLE && start_i) begin
            len_q    <= len_i;
            mode_q   <= mode_i;
            issued   <= '0;
            returned <= '0;
            inflight <= '0;
            acc_vld  <= 1'b0;
        end else begin
            issued   <= issued_n;
            returned <= returned_n;
            inflight <= inflight + IW'(iss) - IW'(ret);
            if (take) begin
                acc     <= red_res_i;
                acc_vld <= 1'b1;
            end
        end
endmodule

// File: tb/tb_sfm_minmax_row_ctrl.sv
// tb_sfm_minmax_row_ctrl: scoreboard bench with a randomized datapath model and a queue-based row reference.
module tb_sfm_minmax_row_ctrl;
    import sfm_pkg::*;
    localparam int W = 16, LW = 16, MI = 2;

    typedef struct packed {logic strb; logic [W-1:0] d;} beat_t;

    logic clk = 0, rst_i = 1, clear_i = 0, start_i = 0, in_valid_i = 0, red_ready_i = 0;
    logic red_res_valid_i = 0, red_res_strb_i = 0, result_ready_i = 0;
    logic [LW-1:0] len_i = '0;
    logic [W-1:0]  red_res_i = '0;
    min_max_mode_t mode_i = MIN;
    logic in_ready_o, red_valid_o, red_res_ready_o, result_valid_o, result_strb_o, busy_o, done_o;
    logic [W-1:0] result_o;
    min_max_mode_t red_mode_o;

    int checks = 0, errors = 0, n_iss = 0, n_acc = 0, rdy_pct = 100;
    bit hold_ret = 0;
    beat_t src[$], pend[$], exp_q[$];

    sfm_minmax_row_ctrl #(.WIDTH(W), .LEN_WIDTH(LW), .MAX_INFLIGHT(MI)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i), .len_i(len_i), .mode_i(mode_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .red_valid_o(red_valid_o), .red_ready_i(red_ready_i),
        .red_mode_o(red_mode_o), .red_res_valid_i(red_res_valid_i), .red_res_ready_o(red_res_ready_o),
        .red_res_i(red_res_i), .red_res_strb_i(red_res_strb_i), .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i), .result_o(result_o), .result_strb_o(result_strb_o),
        .busy_o(busy_o), .done_o(done_o));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask

    // Numeric order of a sign-magnitude value; -0 sorts just below +0.
    function automatic int ord(input logic [W-1:0] x);
        return x[W-1] ? -int'(x[W-2:0]) - 1 : int'(x[W-2:0]);
    endfunction

    function automatic beat_t ref_row(input min_max_mode_t m, input beat_t b[$]);
        beat_t r = '0;
        foreach (b[i])
            if (b[i].strb && (!r.strb || (m == MAX ? ord(b[i].d) > ord(r.d) : ord(b[i].d) < ord(r.d))))
                r = b[i];
        return r;
    endfunction

    task automatic cycle();
        @(negedge clk);
        in_valid_i      = $urandom_range(0, 3) != 0;
        red_ready_i     = $urandom_range(0, 99) < rdy_pct;
        result_ready_i  = $urandom_range(0, 1) == 1;
        red_res_valid_i = !hold_ret && pend.size() > 0 && $urandom_range(0, 2) != 0;
        red_res_i       = pend.size() > 0 ? pend[0].d : '0;
        red_res_strb_i  = pend.size() > 0 ? pend[0].strb : 1'b0;
        #1;
        if (red_res_valid_i && red_res_ready_o) void'(pend.pop_front());
        if (red_valid_o && red_ready_i) begin
            n_iss++;
            pend.push_back(src.size() > 0 ? src.pop_front() : '0);
            chk("inflight_limit", 32'(pend.size() <= MI), 1);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready_o), 0);
        chk({tag, "_red_valid"}, 32'(red_valid_o), 0);
        chk({tag, "_res_ready"}, 32'(red_res_ready_o), 0);
        chk({tag, "_result_valid"}, 32'(result_valid_o), 0);
        chk({tag, "_result_strb"}, 32'(result_strb_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
        chk({tag, "_result"}, 32'(result_o), 0);
        chk({tag, "_mode"}, 32'(red_mode_o), 0);
    endtask

    task automatic run_row(input min_max_mode_t m, input beat_t b[$], input int hold);
        int acc0 = n_acc, iss0 = n_iss, t;
        src = b;
        exp_q.push_back(ref_row(m, b));
        start_i = 1; len_i = LW'(b.size()); mode_i = m;
        hold_ret = hold > 0;
        cycle();
        start_i = 0;
        chk("mode_latched", 32'(red_mode_o), 32'(m));
        if (b.size() == 0) chk("len0_out", 32'(result_valid_o), 1);
        if (hold > 0) begin
            repeat (hold) cycle();
            chk("hold_issues", 32'(n_iss - iss0), 32'(b.size() < MI ? b.size() : MI));
            chk("hold_in_ready", 32'(in_ready_o), 0);
            hold_ret = 0;
        end
        for (t = 0; t < 2000 && n_acc == acc0; t++) cycle();
        if (n_acc == acc0) chk("row_timeout", 0, 1);
        chk("row_issue_count", 32'(n_iss - iss0), 32'(b.size()));
    endtask

    always @(negedge clk) begin
        beat_t e;
        #2;
        if (result_valid_o && result_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_result", 0, 1);
            else begin
                e = exp_q.pop_front();
                chk("result_strb", 32'(result_strb_o), 32'(e.strb));
                if (e.strb) chk("result_value", 32'(result_o), 32'(e.d));
                chk("done_on_accept", 32'(done_o), 1);
            end
            n_acc++;
        end else if (done_o) chk("done_pulse", 32'(done_o), 0);
    end

    initial begin
        beat_t b[$];
        #12;
        chk_reset_outs("reset");
        @(negedge clk);
        rst_i = 0;
        run_row(MAX, '{'{1'b1, 16'h3F80}, '{1'b1, 16'hC000}, '{1'b1, 16'h4040}}, 0);
        run_row(MIN, '{'{1'b1, 16'h3F80}, '{1'b1, 16'hC000}, '{1'b1, 16'h4040}}, 0);
        run_row(MAX, '{'{1'b1, 16'hBF80}, '{1'b1, 16'hC000}}, 0);
        b.delete();
        run_row(MAX, b, 0);
        run_row(MAX, '{'{1'b1, 16'h0001}, '{1'b1, 16'h8005}, '{1'b1, 16'h7F00}, '{1'b1, 16'h0000}, '{1'b1, 16'hFF00}}, 20);
        run_row(MIN, '{'{1'b0, 16'h1234}, '{1'b0, 16'h8765}}, 0);
        // Soft clear while draining two held-back returns.
        src = '{'{1'b1, 16'h1111}, '{1'b1, 16'h2222}};
        hold_ret = 1; start_i = 1; len_i = 2; mode_i = MAX;
        cycle();
        start_i = 0;
        repeat (15) cycle();
        chk("drain_busy", 32'(busy_o), 1);
        chk("drain_no_issue", 32'(in_ready_o), 0);
        clear_i = 1;
        cycle();
        clear_i = 0;
        chk("clear_busy", 32'(busy_o), 0);
        chk("clear_res_ready", 32'(red_res_ready_o), 0);
        chk("clear_result_valid", 32'(result_valid_o), 0);
        chk("clear_done", 32'(done_o), 0);
        pend.delete(); src.delete(); hold_ret = 0;
        run_row(MIN, '{'{1'b1, 16'h4000}, '{1'b1, 16'hC100}, '{1'b1, 16'h3000}}, 0);
        // Asynchronous reset in the middle of a row.
        src = '{'{1'b1, 16'h1}, '{1'b1, 16'h2}, '{1'b1, 16'h3}, '{1'b1, 16'h4}, '{1'b1, 16'h5}};
        hold_ret = 1; start_i = 1; len_i = 5; mode_i = MAX;
        cycle();
        start_i = 0;
        repeat (3) cycle();
        chk("run_busy", 32'(busy_o), 1);
        #1 rst_i = 1;
        #1 chk_reset_outs("async_rst");
        cycle();
        cycle();
        rst_i = 0;
        pend.delete(); src.delete(); hold_ret = 0;
        run_row(MAX, '{'{1'b1, 16'h8001}, '{1'b1, 16'h8000}, '{1'b1, 16'hC000}}, 0);
        rdy_pct = 70;
        repeat (25) begin
            int n = $urandom_range(0, 8);
            b.delete();
            for (int i = 0; i < n; i++) b.push_back('{$urandom_range(0, 5) != 0, W'($urandom)});
            run_row(min_max_mode_t'($urandom_range(0, 1)), b, 0);
        end
        repeat (4) cycle();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sfm_minmax_row_ctrl.md
SFM_MINMAX_ROW_CTRL -- requirements
Module: sfm_minmax_row_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the FP element and result width in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, meaning the width of the row-length counter.
REQ-003 SHALL have parameter MAX_INFLIGHT, default 4, meaning the maximum number of beats issued to the reduction datapath and not yet returned (≥1).
REQ-004 SHALL have ports `clk_i` input 1 (clock) and `rst_i` input 1; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port `clear_i` input 1: synchronous soft clear.
REQ-006 SHALL have ports `start_i` input 1 (start pulse), `len_i` input LEN_WIDTH (beats in row) and `mode_i` input sfm_pkg::min_max_mode_t (MIN/MAX).
REQ-007 SHALL have ports `in_valid_i` input 1 and `in_ready_o` output 1: upstream vector-beat handshake; the data itself goes straight to the datapath.
REQ-008 SHALL have ports `red_valid_o` output 1, `red_ready_i` input 1 and `red_mode_o` output min_max_mode_t: the datapath issue side.
REQ-009 SHALL have ports `red_res_valid_i` input 1, `red_res_ready_o` output 1, `red_res_i` input WIDTH and `red_res_strb_i` input 1: datapath per-beat result.
REQ-010 SHALL have ports `result_valid_o` output 1, `result_ready_i` input 1, `result_o` output WIDTH and `result_strb_o` output 1: row result.
REQ-011 SHALL have ports `busy_o` output 1 (state≠IDLE) and `done_o` output 1 (one-cycle pulse on result accept).

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN and OUT.
REQ-013 SHALL, in IDLE with `start_i`=1, latch len and mode, zero counters `issued`/`returned`/`inflight`, clear `acc_vld`, and go to RUN (or OUT if len=0).
REQ-014 SHALL ignore `start_i` outside IDLE.
REQ-015 SHALL define `issue_en` = (state==RUN) & (issued<len) & (inflight<MAX_INFLIGHT).
REQ-016 SHALL drive `red_valid_o` = `in_valid_i`&`issue_en` and `in_ready_o` = `red_ready_i`&`issue_en`, with no combinational path from `red_valid_o` to `red_ready_i`.
REQ-017 SHALL count an issue on `red_valid_o`&`red_ready_i`: `issued`+1, `inflight`+1.
REQ-018 SHALL count a return on `red_res_valid_i`&`red_res_ready_o`: `returned`+1, `inflight`-1.
REQ-019 SHALL keep `inflight` unchanged when an issue and a return occur in the same cycle.
REQ-020 SHALL drive `red_res_ready_o`=1 in RUN and DRAIN, and 0 otherwise.
REQ-021 SHALL drive `red_mode_o` = latched mode.
REQ-022 SHALL go RUN→DRAIN on the cycle `issued` reaches len.
REQ-023 SHALL go DRAIN→OUT on the cycle `returned` reaches len; if the last issue and last return coincide, SHALL go RUN→OUT directly.
REQ-024 SHALL fold a returned beat with `red_res_strb_i`=0 into the counters only; the accumulator is unchanged.
REQ-025 SHALL form the order key as key(x) = x[W-1] ? ~x : x|(1<<(W-1)), compared unsigned.
REQ-026 SHALL, on a returned beat with strb=1: if `acc_vld`=0, load acc and set `acc_vld`; else MAX replaces acc when key(res)>key(acc) and MIN replaces acc when key(res)<key(acc); ties keep acc.
REQ-027 SHALL, in OUT, hold `result_valid_o`=1, `result_o`=acc and `result_strb_o`=`acc_vld` stable until `result_ready_i`.
REQ-028 SHALL, on OUT with `result_ready_i`, go to IDLE and pulse `done_o` for 1 cycle.
REQ-029 SHALL, on `clear_i` (any state, priority over all else), go to IDLE, zero counters, clear `acc_vld` and leave `done_o`=0.
REQ-030 SHALL give `result_valid_o` a minimum latency of 1 cycle after the last return.

Reset
REQ-031 SHALL, on `rst_i`=1 (asynchronous, also mid-row), force IDLE, all counters 0, acc=0, `acc_vld`=0, and outputs `in_ready_o`/`red_valid_o`/`red_res_ready_o`/`result_valid_o`/`result_strb_o`/`busy_o`/`done_o`=0, `result_o`=0 and `red_mode_o`=MIN encoding 0.
REQ-032 SHALL resume normal operation on the first clock edge after reset deassertion.

Verification
REQ-033 SHALL be covered by this test: MAX, len=3, BF16 results 0x3F80, 0xC000, 0x4040 -> `result_o`=0x4040, strb=1, `done_o` one pulse.
REQ-034 SHALL be covered by this test: MIN, same stream -> 0xC000; then MAX with results 0xBF80, 0xC000 -> 0xBF80.
REQ-035 SHALL be covered by this test: len=0 -> OUT next cycle, `result_strb_o`=0, no issue.
REQ-036 SHALL be covered by this test: MAX_INFLIGHT=2, len=5, `red_res_valid_i` held 0 -> exactly 2 issues, `in_ready_o`=0; release returns -> all 5 issue, result correct.
REQ-037 SHALL be covered by this test: all-strb=0 returns, len=2 -> `result_strb_o`=0; simultaneous issue+return keeps `inflight` constant.
REQ-038 SHALL be covered by this test: `clear_i` in DRAIN and `rst_i` in RUN -> IDLE next cycle/immediately, outputs at reset values, and a subsequent start gives the correct result.
